// File: rtl/mem_bus_arbiter_if.sv
// Memory bus between the arbiter (master) and the memory controller (slave).
// One-cycle start pulse out, one-cycle done pulse with read data back.
interface mem_bus_arbiter_if;
   logic [26:0] addr;
   logic [31:0] data;
   logic        we;
   logic        start;
   logic [31:0] q;
   logic        done;

   modport master (output addr, output data, output we, output start,
                   input q, input done);
   modport slave  (input addr, input data, input we, input start,
                   output q, output done);
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (A = CPU, B = DMA/GPU) arbiter onto a single memory bus.
// Fixed A-first priority by default; define ARB_ROUND_ROBIN_EN for round-robin.
module mem_bus_arbiter (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [26:0]             a_addr,
   input  logic [31:0]             a_data,
   input  logic                    a_we,
   input  logic                    a_start,
   output logic [31:0]             a_q,
   output logic                    a_done,
   input  logic [26:0]             b_addr,
   input  logic [31:0]             b_data,
   input  logic                    b_we,
   input  logic                    b_start,
   output logic [31:0]             b_q,
   output logic                    b_done,
   mem_bus_arbiter_if.master       bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t      state, state_nx;
   logic        pend_a, pend_b;
   logic [26:0] pa_addr, pb_addr;
   logic [31:0] pa_data, pb_data;
   logic        pa_we, pb_we;
   logic        owner;          // 0 = A, 1 = B
   logic        grant, grant_b;
   logic        complete;
   logic        busy_a, busy_b;

`ifdef ARB_ROUND_ROBIN_EN
   logic        last_b;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      grant_b  = 1'b0;
      case (state)
         IDLE: begin
            if (pend_a | pend_b) begin
               grant = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
               grant_b = pend_b & (~pend_a | ~last_b);
`else
               grant_b = ~pend_a;
`endif
               state_nx = ISSUE;
            end
         end
         ISSUE:   state_nx = WAIT;
         WAIT:    if (bus.done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.start = (state == ISSUE);
   assign complete  = (state == WAIT) & bus.done;
   assign busy_a    = (state != IDLE) & ~owner;
   assign busy_b    = (state != IDLE) &  owner;

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_a   <= 1'b0;
         pend_b   <= 1'b0;
         pa_addr  <= '0;
         pa_data  <= '0;
         pa_we    <= 1'b0;
         pb_addr  <= '0;
         pb_data  <= '0;
         pb_we    <= 1'b0;
         owner    <= 1'b0;
         bus.addr <= '0;
         bus.data <= '0;
         bus.we   <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         a_done   <= 1'b0;
         b_done   <= 1'b0;
      end else begin
         a_done <= complete & ~owner;
         b_done <= complete &  owner;
         if (complete) begin
            if (owner) b_q <= bus.q;
            else       a_q <= bus.q;
         end

         // A pending grant clears only a set pend_x, and capture needs it clear,
         // so the two branches can never collide on the same edge.
         if (a_start & ~pend_a & ~busy_a) begin
            pend_a  <= 1'b1;
            pa_addr <= a_addr;
            pa_data <= a_data;
            pa_we   <= a_we;
         end else if (grant & ~grant_b) begin
            pend_a <= 1'b0;
         end

         if (b_start & ~pend_b & ~busy_b) begin
            pend_b  <= 1'b1;
            pb_addr <= b_addr;
            pb_data <= b_data;
            pb_we   <= b_we;
         end else if (grant & grant_b) begin
            pend_b <= 1'b0;
         end

         if (grant) begin
            owner    <= grant_b;
            bus.addr <= grant_b ? pb_addr : pa_addr;
            bus.data <= grant_b ? pb_data : pa_data;
            bus.we   <= grant_b ? pb_we   : pa_we;
         end
      end
   end

`ifdef ARB_ROUND_ROBIN_EN
   always_ff @(posedge clk) begin
      if (reset)      last_b <= 1'b1;
      else if (grant) last_b <= grant_b;
   end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: bench drives the memory side by hand
// and checks grant order, latency, bus stability, completions and reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [26:0] a_addr, b_addr;
   logic [31:0] a_data, b_data;
   logic        a_we, b_we, a_start, b_start;
   logic [31:0] a_q, b_q;
   logic        a_done, b_done;

   mem_bus_arbiter_if bus ();

   mem_bus_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .a_addr  (a_addr),
      .a_data  (a_data),
      .a_we    (a_we),
      .a_start (a_start),
      .a_q     (a_q),
      .a_done  (a_done),
      .b_addr  (b_addr),
      .b_data  (b_data),
      .b_we    (b_we),
      .b_start (b_start),
      .b_q     (b_q),
      .b_done  (b_done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;
   int n_starts    = 0;

   always @(posedge clk) if (bus.start === 1'b1) n_starts++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Pulse starts for one cycle; returns at the negedge after the capture edge.
   task automatic req(input bit da, input bit db,
                      input logic [26:0] aa, input logic [31:0] ad, input logic aw,
                      input logic [26:0] ba, input logic [31:0] bd, input logic bw);
      a_start = da; a_addr = aa; a_data = ad; a_we = aw;
      b_start = db; b_addr = ba; b_data = bd; b_we = bw;
      @(negedge clk);
      a_start = 1'b0;
      b_start = 1'b0;
   endtask

   task automatic expect_issue(input string tag, input int exp_lat,
                               input logic [26:0] addr, input logic [31:0] data, input logic we);
      int lat;
      for (lat = 0; bus.start !== 1'b1 && lat < 8; lat++) @(negedge clk);
      chk({tag, "_start"}, {31'b0, bus.start}, 32'd1);
      chk({tag, "_lat"},   lat,                exp_lat);
      chk({tag, "_addr"},  {5'b0, bus.addr},   {5'b0, addr});
      chk({tag, "_data"},  bus.data,           data);
      chk({tag, "_we"},    {31'b0, bus.we},    {31'b0, we});
   endtask

   // Called at the ISSUE-cycle negedge; bus_done goes high 'delay' cycles later.
   task automatic complete(input string tag, input bit is_b,
                           input logic [26:0] addr, input logic [31:0] data, input logic we,
                           input logic [31:0] rsp, input int delay);
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk({tag, "_hold_start"}, {31'b0, bus.start}, 32'd0);
         chk({tag, "_hold_addr"},  {5'b0, bus.addr},   {5'b0, addr});
         chk({tag, "_hold_data"},  bus.data,           data);
         chk({tag, "_hold_we"},    {31'b0, bus.we},    {31'b0, we});
      end
      bus.done = 1'b1;
      bus.q    = rsp;
      @(negedge clk);
      bus.done = 1'b0;
      bus.q    = 32'h0;
      chk({tag, "_done"},  {31'b0, is_b ? b_done : a_done}, 32'd1);
      chk({tag, "_other"}, {31'b0, is_b ? a_done : b_done}, 32'd0);
      chk({tag, "_q"},     is_b ? b_q : a_q,                rsp);
      @(negedge clk);
      chk({tag, "_done_low"}, {31'b0, is_b ? b_done : a_done}, 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_a_q"},    a_q,                 32'h0);
      chk({tag, "_b_q"},    b_q,                 32'h0);
      chk({tag, "_dones"},  {30'b0, a_done, b_done}, 32'h0);
      chk({tag, "_start"},  {31'b0, bus.start},  32'h0);
      chk({tag, "_we"},     {31'b0, bus.we},     32'h0);
      chk({tag, "_addr"},   {5'b0, bus.addr},    32'h0);
      chk({tag, "_data"},   bus.data,            32'h0);
   endtask

   initial begin
      bit first_b;
      int s0;

      reset = 1'b1;
      a_start = 0; b_start = 0; a_addr = '0; b_addr = '0;
      a_data = '0; b_data = '0; a_we = 0; b_we = 0;
      bus.done = 1'b0; bus.q = '0;
      repeat (3) @(negedge clk);
      check_reset_values("rst");
      reset = 1'b0;
      @(negedge clk);

      // single read from A
      req(1, 0, 27'h0000100, 32'h11111111, 0, '0, '0, 0);
      expect_issue("rd", 1, 27'h0000100, 32'h11111111, 0);
      complete("rd", 0, 27'h0000100, 32'h11111111, 0, 32'hDEADBEEF, 3);
      chk("rd_b_q", b_q, 32'h0);
      chk("rd_starts", n_starts, 1);

      // single write from B at the top address
      req(0, 1, '0, '0, 0, 27'h7FFFFFF, 32'h12345678, 1);
      expect_issue("wr", 1, 27'h7FFFFFF, 32'h12345678, 1);
      complete("wr", 1, 27'h7FFFFFF, 32'h12345678, 1, 32'hCAFEF00D, 4);
      chk("wr_a_q", a_q, 32'hDEADBEEF);
      chk("wr_starts", n_starts, 2);

      // contention: A wins, B issues in the cycle after a_done
      req(1, 1, 27'h0AAAAAA, 32'h0, 0, 27'h0BBBBBB, 32'h0, 0);
      expect_issue("c1a", 1, 27'h0AAAAAA, 32'h0, 0);
      complete("c1a", 0, 27'h0AAAAAA, 32'h0, 0, 32'h0000A001, 1);
      expect_issue("c1b", 0, 27'h0BBBBBB, 32'h0, 0);
      complete("c1b", 1, 27'h0BBBBBB, 32'h0, 0, 32'h0000B001, 2);
      chk("c1_starts", n_starts, 4);

      // uncontested A write, then a second contested pair
      req(1, 0, 27'h0000200, 32'h55AA55AA, 1, '0, '0, 0);
      expect_issue("sa", 1, 27'h0000200, 32'h55AA55AA, 1);
      complete("sa", 0, 27'h0000200, 32'h55AA55AA, 1, 32'h13572468, 1);

`ifdef ARB_ROUND_ROBIN_EN
      first_b = 1'b1;
`else
      first_b = 1'b0;
`endif
      req(1, 1, 27'h0000300, 32'h0, 0, 27'h0000400, 32'h0, 0);
      if (first_b) begin
         expect_issue("c2b", 1, 27'h0000400, 32'h0, 0);
         complete("c2b", 1, 27'h0000400, 32'h0, 0, 32'h0000B002, 1);
         expect_issue("c2a", 0, 27'h0000300, 32'h0, 0);
         complete("c2a", 0, 27'h0000300, 32'h0, 0, 32'h0000A002, 1);
      end else begin
         expect_issue("c2a", 1, 27'h0000300, 32'h0, 0);
         complete("c2a", 0, 27'h0000300, 32'h0, 0, 32'h0000A002, 1);
         expect_issue("c2b", 0, 27'h0000400, 32'h0, 0);
         complete("c2b", 1, 27'h0000400, 32'h0, 0, 32'h0000B002, 1);
      end
      chk("c2_starts", n_starts, 7);

      // back-to-back: A arrives during B's WAIT; repeat starts are ignored
      req(0, 1, '0, '0, 0, 27'h0001000, 32'hA5A5A5A5, 1);
      expect_issue("bb_b", 1, 27'h0001000, 32'hA5A5A5A5, 1);
      fork
         complete("bb_b", 1, 27'h0001000, 32'hA5A5A5A5, 1, 32'h00000B0B, 3);
         begin
            @(negedge clk);
            a_start = 1; a_addr = 27'h0002000; a_data = 32'h0; a_we = 0;
            b_start = 1; b_addr = 27'h0003000; b_data = 32'hFFFFFFFF; b_we = 0;
            @(negedge clk);
            b_start = 0;
            a_addr = 27'h0004000;
            @(negedge clk);
            a_start = 0;
         end
      join
      expect_issue("bb_a", 0, 27'h0002000, 32'h0, 0);
      complete("bb_a", 0, 27'h0002000, 32'h0, 0, 32'h00000A0A, 1);
      repeat (4) @(negedge clk);
      chk("bb_starts", n_starts, 9);

      // reset during WAIT with B pending, bus_done right after reset
      req(1, 0, 27'h0005000, 32'h0, 0, '0, '0, 0);
      expect_issue("rw", 1, 27'h0005000, 32'h0, 0);
      @(negedge clk);
      b_start = 1; b_addr = 27'h0006000; b_data = 32'h0; b_we = 0;
      @(negedge clk);
      b_start = 0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.done = 1'b1;
      bus.q = 32'hFFFFFFFF;
      check_reset_values("rw_rst");
      s0 = n_starts;
      @(negedge clk);
      bus.done = 1'b0;
      check_reset_values("rw_post");
      repeat (5) @(negedge clk);
      chk("rw_idle_starts", n_starts, s0);
      chk("rw_idle_q", a_q | b_q, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a_addr  input  27  requester A (CPU) word address; valid while a_start=1.
REQ-005 a_data  input  32  requester A write data; valid while a_start=1.
REQ-006 a_we  input  1  requester A write enable; valid while a_start=1.
REQ-007 a_start  input  1  requester A one-cycle request pulse.
REQ-008 a_q  output  32  requester A read data; registered.
REQ-009 a_done  output  1  requester A one-cycle completion pulse; registered.
REQ-010 b_addr, b_data, b_we, b_start, b_q, b_done  SHALL mirror REQ-004..REQ-009 for requester B (DMA/GPU).
REQ-011 bus_addr  output  27  memory bus address.
REQ-012 bus_data  output  32  memory bus write data.
REQ-013 bus_we  output  1  memory bus write enable.
REQ-014 bus_start  output  1  memory bus one-cycle start pulse.
REQ-015 bus_q  input  32  memory bus read data; valid when bus_done=1.
REQ-016 bus_done  input  1  memory bus completion pulse; never asserted in the same cycle as bus_start.

Function
REQ-017 On each rising edge with x_start=1, the block SHALL capture x_addr/x_data/x_we into a per-requester pending register and set pend_x, regardless of FSM state.
REQ-018 A start from a requester whose pend_x is already set, or whose transaction is in flight, SHALL be ignored (protocol violation; no state change).
REQ-019 FSM states: IDLE, ISSUE, WAIT; reset state IDLE.
REQ-020 IDLE: if any pend_x is set at the edge, select owner per REQ-025, clear that pend_x, load bus_addr/bus_data/bus_we from its pending register, go to ISSUE; otherwise stay in IDLE.
REQ-021 ISSUE: bus_start=1 for exactly this one cycle; next edge go to WAIT.
REQ-022 WAIT: bus_addr/bus_data/bus_we held stable; at the edge with bus_done=1, latch bus_q into owner's x_q, assert owner's x_done for the following cycle only, go to IDLE.
REQ-023 Minimum latency: x_start at edge N, bus_start high in cycle N+1..N+2 window, x_done high the cycle after the bus_done edge; a new grant SHALL be possible in the cycle x_done is high.
REQ-024 x_q SHALL hold its value until the next completion for that requester; writes SHALL also update x_q with bus_q.
REQ-025 Default priority: when both pend_a and pend_b are set in IDLE, A SHALL be granted.
REQ-026 bus_done outside WAIT SHALL be ignored; the non-owner's x_done SHALL never pulse.
REQ-027 Simultaneous a_start and b_start SHALL both be captured; grant order per REQ-025 or REQ-030.

Reset
REQ-028 During reset: state=IDLE, pend_a=pend_b=0, bus_start=0, bus_we=0, bus_addr=0, bus_data=0, a_q=b_q=0, a_done=b_done=0, last grant=B.
REQ-029 Reset mid-transaction SHALL abandon it: no x_done pulse, pending requests discarded, and bus_done in the first cycle after reset ignored.

Configuration
REQ-030 With macro ARB_ROUND_ROBIN_EN defined, a contested grant SHALL go to the requester not granted last (first contested grant after reset goes to A); uncontested grants update last-grant too.
REQ-031 Without ARB_ROUND_ROBIN_EN, fixed priority per REQ-025 SHALL apply and no last-grant register SHALL exist.

Verification
REQ-032 Single read: a_start, a_addr=0x0000100, a_we=0; bus_done 3 cycles after bus_start with bus_q=0xDEADBEEF -> one bus_start pulse with bus_addr=0x0000100, a_q=0xDEADBEEF, a_done one cycle, b_done stays 0.
REQ-033 Single write: b_start, b_addr=0x7FFFFFF, b_data=0x12345678, b_we=1 -> bus_we=1, bus_addr/bus_data match and stay stable through WAIT, b_done one cycle.
REQ-034 Contention: a_start and b_start same cycle -> A served first, B's bus_start in cycle after a_done; with ARB_ROUND_ROBIN_EN and a second simultaneous pair, B served first in second pair.
REQ-035 Back-to-back: a_start issued during B's WAIT -> A granted in IDLE immediately after b_done, no lost request, one bus_start per transaction.
REQ-036 Reset in WAIT, then bus_done=1 next cycle -> no x_done, all outputs at reset values, FSM IDLE.
